bcd_to_dec_scan: RTL
====================

# bcd_to_dec_scan

Time-multiplexed BCD-to-decimal decoder for multi-digit one-of-ten displays (Nixie/10-LED columns), the output-side counterpart of the keypad decimal-to-BCD encoder. It accepts a packed word of BCD digits through a valid/ready handshake, double-buffers it, and scans the digits one at a time. For each digit it drives a one-hot 10-line decimal output and a one-hot digit select, with a blanking gap between digits to suppress ghosting. Code 4'b1111 means "no digit" and blanks the position, matching the encoder's no-key code.

## Interface
- DIGITS, 4, number of scanned digit positions (≥1)
- DWELL, 1000, cycles each digit is shown (≥1)
- BLANK, 50, cycles of blanking before each digit (≥1)
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- bcd_in  input  4*DIGITS  packed digits; bits [3:0] = digit 0
- in_valid  input  1  bcd_in valid
- in_ready  output  1  pending buffer empty; transfer when in_valid && in_ready
- dec  output  10  one-hot decimal; bit n high = value n; all-zero = blank
- digit_sel  output  DIGITS  one-hot active digit; all-zero during blanking
- code_err  output  1  high while the shown digit holds an illegal code 1010–1110

## Operation
- Two registers: `pending` (plus a pending_full flag) and `display` (DIGITS×4).
- Handshake: on transfer, bcd_in is copied to pending and pending_full is set. in_ready = !pending_full.
- Display update: at the frame boundary (transition from last digit's SHOW to digit 0's BLANK), if pending_full, display ← pending and pending_full is cleared. The display is never modified mid-frame.
- If a transfer and a frame-boundary load happen in the same cycle: the boundary consumes the old pending; the new word cannot transfer because in_ready was low. When in_ready is high at the boundary, a transfer that cycle sets pending and does not reach display until the next frame.
- FSM states:
  - BLANK: digit_sel=0, dec=0, code_err=0. Runs BLANK cycles, then goes to SHOW for the same digit.
  - SHOW: digit_sel bit i high; dec and code_err from decode(display[i]). Runs DWELL cycles, then goes to BLANK. The digit index increments, wrapping DIGITS−1 → 0.
- Decode:
  - 0–9 → dec = 1<<n, code_err=0.
  - 1111 → dec=0, code_err=0.
  - 1010–1110 → dec=0, code_err=1.
- Counter width: clog2(max(DWELL,BLANK)). It counts 0..N−1 and resets to 0 on each state change.

## Timing
- Reset, in the cycle after rst is sampled high:
  - dec=0, digit_sel=0, code_err=0, in_ready=1
  - state=BLANK, index=0, counter=0
  - every display digit=1111, pending_full=0
- rst has priority over every other event, including a transfer in the same cycle; that word is dropped.
- Outputs are registered and reflect the current state/index/display with no combinational path from inputs.
- Frame period: exactly DIGITS*(BLANK+DWELL) cycles. SHOW of digit i starts i*(BLANK+DWELL)+BLANK cycles after frame start.
- Load latency: a word transferred during frame k is displayed starting at frame k+1. Digit 0 is visible BLANK cycles after that frame boundary.
- in_ready falls the cycle after a transfer. It rises the cycle after the frame boundary that consumes pending.
- The handshake has no effect on scan timing; the scan runs continuously from reset.

## Test plan
- Reset check (DIGITS=4, DWELL=4, BLANK=1): no loads → digit_sel cycles 0000,0001×4,0000,0010×4,… with dec=0 and code_err=0 throughout; frame = 20 cycles.
- Load 16'h0391 after reset:
  - in_ready drops; first frame stays blank.
  - Next frame shows digit0 dec=10'b0000000010, digit1 10'b1000000000, digit2 10'b0000001000, digit3 10'b0000000001.
  - in_ready returns after the boundary.
- Backpressure: offer 16'h1111 then 16'h2222 back-to-back. The second word is held (in_ready=0) until the boundary. Displayed frames are 1111 then 2222; no word is lost.
- Illegal codes: load 16'hF0AF → digit0 blank with code_err=0, digit1 blank with code_err=1, digit2 dec=10'b1, digit3 blank with code_err=0.
- Boundary collision: assert in_valid with in_ready=1 exactly on the boundary cycle. The word becomes pending and appears one frame later; the current frame keeps its old digits.
- Mid-frame reset during SHOW of digit 2 with pending_full=1 → next cycle: all outputs 0, in_ready=1, scan restarts at digit 0 BLANK, display all blank.

Source files
------------

// File: rtl/bcd_to_dec_scan.sv
// Time-multiplexed BCD to one-of-ten decoder for multi-digit displays.
// Words arrive through a valid/ready handshake into a pending buffer and are
// promoted to the display only at the frame boundary.
//
// state   | meaning
// S_BLANK | blanking gap before the current digit, all outputs low
// S_SHOW  | current digit selected and decoded onto dec/code_err
module bcd_to_dec_scan #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 50
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [9:0]          dec,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                code_err
);

    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } state_t;

    state_t              state;
    state_t              nxt_state;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       nxt_idx;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       nxt_cnt;
    logic                boundary;

    logic [3:0]          display [DIGITS];
    logic [4*DIGITS-1:0] pending;
    logic                pending_full;

    logic [3:0]          nxt_code;
    logic [9:0]          nxt_dec;
    logic                nxt_err;
    logic [DIGITS-1:0]   nxt_sel;

    assign in_ready = ~pending_full;

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt + 1'b1;
        boundary  = 1'b0;
        if (state == S_BLANK) begin
            if (cnt == BLANK_LAST) begin
                nxt_state = S_SHOW;
                nxt_cnt   = '0;
            end
        end else begin
            if (cnt == DWELL_LAST) begin
                nxt_state = S_BLANK;
                nxt_cnt   = '0;
                boundary  = (idx == IDX_LAST);
                nxt_idx   = boundary ? '0 : idx + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with it once
    // registered. The display never changes on an edge that enters SHOW.
    always_comb begin
        nxt_code = display[nxt_idx];
        nxt_dec  = '0;
        nxt_err  = 1'b0;
        nxt_sel  = '0;
        if (nxt_state == S_SHOW) begin
            nxt_sel = DIGITS'(1) << nxt_idx;
            if (nxt_code <= 4'd9) begin
                nxt_dec = 10'(1) << nxt_code;
            end else if (nxt_code != 4'hF) begin
                nxt_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_BLANK;
            idx          <= '0;
            cnt          <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                display[i] <= 4'hF;
            end
            dec          <= '0;
            digit_sel    <= '0;
            code_err     <= 1'b0;
        end else begin
            state     <= nxt_state;
            idx       <= nxt_idx;
            cnt       <= nxt_cnt;
            dec       <= nxt_dec;
            digit_sel <= nxt_sel;
            code_err  <= nxt_err;
            // Load and transfer are exclusive: a transfer needs pending empty.
            if (boundary && pending_full) begin
                for (int i = 0; i < DIGITS; i++) begin
                    display[i] <= pending[4*i +: 4];
                end
                pending_full <= 1'b0;
            end
            if (in_valid && !pending_full) begin
                pending      <= bcd_in;
                pending_full <= 1'b1;
            end
        end
    end

endmodule
